// File: rtl/instr_fetch_unit.sv
// Fetch stage of the 16-bit RISC core: program counter, synchronous-read imem
// addressing, one-bubble jump/branch redirect and decode-stall hold.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        jump,
  input  logic        beq,
  input  logic        bne,
  input  logic        alu_zero,
  output logic [15:0] instr,
  output logic [3:0]  opcode,
  output logic [15:0] pc,
  output logic [15:0] pc_plus1,
  output logic        instr_valid,
  output logic        redirect
);

  logic [15:0] r_fetch_pc;
  logic [15:0] r_dec_pc;
  logic        r_valid_d;

  logic        w_hold;
  logic        w_taken;
  logic [15:0] w_instr;
  logic [15:0] w_pc_plus1;
  logic [15:0] w_jump_tgt;
  logic [15:0] w_br_tgt;
  logic [15:0] w_target;

  assign w_hold     = stall & r_valid_d;
  assign w_instr    = r_valid_d ? imem_rdata : NOP_INSTR;
  assign w_pc_plus1 = r_dec_pc + 16'd1;
  assign w_taken    = r_valid_d & ~stall &
                      (jump | (beq & alu_zero) | (bne & ~alu_zero));

  // Jump stays within the 4K page of pc+1; branches are pc+1 relative.
  assign w_jump_tgt = {w_pc_plus1[15:12], w_instr[11:0]};
  assign w_br_tgt   = w_pc_plus1 + {{10{w_instr[5]}}, w_instr[5:0]};
  assign w_target   = jump ? w_jump_tgt : w_br_tgt;

  // Re-fetching D during a stall keeps imem_rdata stable for decode.
  assign imem_addr   = w_hold ? r_dec_pc : r_fetch_pc;
  assign instr       = w_instr;
  assign opcode      = w_instr[15:12];
  assign pc          = r_dec_pc;
  assign pc_plus1    = w_pc_plus1;
  assign instr_valid = r_valid_d;
  assign redirect    = w_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_dec_pc   <= RESET_PC;
      r_valid_d  <= 1'b0;
    end else if (w_hold) begin
      r_fetch_pc <= r_fetch_pc;
      r_dec_pc   <= r_dec_pc;
      r_valid_d  <= r_valid_d;
    end else if (w_taken) begin
      // The fetch already in flight is wrong-path; squash it as a bubble.
      r_fetch_pc <= w_target;
      r_dec_pc   <= r_dec_pc;
      r_valid_d  <= 1'b0;
    end else begin
      r_dec_pc   <= r_fetch_pc;
      r_fetch_pc <= r_fetch_pc + 16'd1;
      r_valid_d  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed, table-driven bench for instr_fetch_unit: one instance at RESET_PC=0
// and one at RESET_PC=16'hFFFE for the wrap-around cases.
module tb_instr_fetch_unit;

  typedef struct {
    logic        rst, stall, jump, beq, bne, az;
    logic        exp_valid, exp_redir, chk_pc;
    logic [15:0] exp_pc, exp_instr, exp_addr;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];

  // Instance A: RESET_PC = 0
  logic        a_rst, a_stall, a_jump, a_beq, a_bne, a_az;
  logic [15:0] a_addr, a_rdata, a_instr, a_pc, a_pc1;
  logic [3:0]  a_op;
  logic        a_valid, a_redir;

  // Instance W: RESET_PC = 16'hFFFE
  logic        w_rst, w_stall, w_jump, w_beq, w_bne, w_az;
  logic [15:0] w_addr, w_rdata, w_instr, w_pc, w_pc1;
  logic [3:0]  w_op;
  logic        w_valid, w_redir;

  instr_fetch_unit #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0000)) dut (
    .clk(clk), .rst(a_rst), .imem_addr(a_addr), .imem_rdata(a_rdata),
    .stall(a_stall), .jump(a_jump), .beq(a_beq), .bne(a_bne), .alu_zero(a_az),
    .instr(a_instr), .opcode(a_op), .pc(a_pc), .pc_plus1(a_pc1),
    .instr_valid(a_valid), .redirect(a_redir)
  );

  instr_fetch_unit #(.RESET_PC(16'hFFFE), .NOP_INSTR(16'h0000)) dut_wrap (
    .clk(clk), .rst(w_rst), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .stall(w_stall), .jump(w_jump), .beq(w_beq), .bne(w_bne), .alu_zero(w_az),
    .instr(w_instr), .opcode(w_op), .pc(w_pc), .pc_plus1(w_pc1),
    .instr_valid(w_valid), .redirect(w_redir)
  );

  // Synchronous-read instruction memory, one read port per instance
  always @(posedge clk) begin
    a_rdata <= mem[a_addr];
    w_rdata <= mem[w_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, s, j, bq, bn, az,
                              input logic v, rd, cp,
                              input logic [15:0] p, ins, ad);
    vec_t t;
    t.rst = r; t.stall = s; t.jump = j; t.beq = bq; t.bne = bn; t.az = az;
    t.exp_valid = v; t.exp_redir = rd; t.chk_pc = cp;
    t.exp_pc = p; t.exp_instr = ins; t.exp_addr = ad;
    return t;
  endfunction

  // Drive one cycle of inputs, check outputs mid-cycle, then advance a clock.
  task automatic apply(input bit sel, input int idx, input vec_t v);
    logic [15:0] addr, ins, p, p1;
    logic [3:0]  op;
    logic        val, rd;
    if (sel) begin
      w_rst = v.rst; w_stall = v.stall; w_jump = v.jump;
      w_beq = v.beq; w_bne = v.bne; w_az = v.az;
    end else begin
      a_rst = v.rst; a_stall = v.stall; a_jump = v.jump;
      a_beq = v.beq; a_bne = v.bne; a_az = v.az;
    end
    #1;
    addr = sel ? w_addr  : a_addr;
    ins  = sel ? w_instr : a_instr;
    p    = sel ? w_pc    : a_pc;
    p1   = sel ? w_pc1   : a_pc1;
    op   = sel ? w_op    : a_op;
    val  = sel ? w_valid : a_valid;
    rd   = sel ? w_redir : a_redir;
    chk("instr_valid", idx, {15'd0, val}, {15'd0, v.exp_valid});
    chk("redirect", idx, {15'd0, rd}, {15'd0, v.exp_redir});
    chk("imem_addr", idx, addr, v.exp_addr);
    chk("instr", idx, ins, v.exp_instr);
    chk("opcode", idx, {12'd0, op}, {12'd0, v.exp_instr[15:12]});
    if (v.chk_pc) begin
      chk("pc", idx, p, v.exp_pc);
      chk("pc_plus1", idx, p1, v.exp_pc + 16'd1);
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tab_a[$];
  vec_t tab_b[$];
  vec_t tab_w[$];

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h1000 + i[15:0];
    mem[16'h0004] = 16'h103E;  // beq, offset -2
    mem[16'h0005] = 16'h2FF0;  // jump to 0FF0
    mem[16'h1005] = 16'h20A0;  // jump to 10A0
    mem[16'hFFFF] = 16'h3001;  // bne, offset +1

    //                 rst st jp bq bn az  v rd cp  pc        instr     addr
    tab_a.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000));
    tab_a.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000));
    tab_a.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0000, 16'h1000, 16'h0001));
    tab_a.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0001, 16'h1001, 16'h0002));
    tab_a.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 1, 16'h0002, 16'h1002, 16'h0002));
    tab_a.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0, 1, 16'h0002, 16'h1002, 16'h0002));
    tab_a.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 1, 16'h0002, 16'h1002, 16'h0002));
    tab_a.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0002, 16'h1002, 16'h0003));
    tab_a.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0003, 16'h1003, 16'h0004));
    tab_a.push_back(mk(0, 0, 0, 1, 0, 1, 1, 1, 1, 16'h0004, 16'h103E, 16'h0005));
    tab_a.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0003));
    tab_a.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0003, 16'h1003, 16'h0004));
    tab_a.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1, 16'h0004, 16'h103E, 16'h0005));
    tab_a.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 1, 16'h0005, 16'h2FF0, 16'h0006));
    tab_a.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0FF0));
    tab_a.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0FF0, 16'h1FF0, 16'h0FF1));

    tab_b.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 1, 16'h1005, 16'h20A0, 16'h1006));
    tab_b.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h10A0));
    tab_b.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 1, 16'h10A0, 16'h20A0, 16'h10A0));
    tab_b.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000));
    tab_b.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0000, 16'h1000, 16'h0001));
    tab_b.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0001, 16'h1001, 16'h0002));
    tab_b.push_back(mk(1, 0, 1, 0, 0, 0, 1, 1, 1, 16'h0002, 16'h1002, 16'h0003));
    tab_b.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000));
    tab_b.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0000, 16'h1000, 16'h0001));
    tab_b.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0001, 16'h1001, 16'h0002));

    tab_w.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 16'hFFFE, 16'h0000, 16'hFFFE));
    tab_w.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hFFFE, 16'h0000, 16'hFFFE));
    tab_w.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'hFFFE, 16'h0FFE, 16'hFFFF));
    tab_w.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 1, 16'hFFFF, 16'h3001, 16'h0000));
    tab_w.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0000, 16'h1000, 16'h0001));
    tab_w.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0001, 16'h1001, 16'h0002));
    tab_w.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hFFFE, 16'h0000, 16'hFFFE));
    tab_w.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'hFFFE, 16'h0FFE, 16'hFFFF));
    tab_w.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 1, 16'hFFFF, 16'h3001, 16'h0000));
    tab_w.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0001));
    tab_w.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0001, 16'h1001, 16'h0002));

    a_rst = 1'b1; a_stall = 1'b0; a_jump = 1'b0; a_beq = 1'b0; a_bne = 1'b0; a_az = 1'b0;
    w_rst = 1'b1; w_stall = 1'b0; w_jump = 1'b0; w_beq = 1'b0; w_bne = 1'b0; w_az = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    foreach (tab_a[i]) apply(1'b0, i, tab_a[i]);

    // Straight-line run across the 4K page boundary up to the jump at 1005
    for (int k = 16'h0FF1; k <= 16'h1004; k++) begin
      apply(1'b0, 100 + k - 16'h0FF1,
            mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
               k[15:0], 16'h1000 + k[15:0], k[15:0] + 16'd1));
    end

    foreach (tab_b[i]) apply(1'b0, 200 + i, tab_b[i]);

    foreach (tab_w[i]) apply(1'b1, 300 + i, tab_w[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage of the 16-bit RISC core. Holds the program counter, drives a synchronous-read instruction memory, and presents each fetched instruction, its PC and its 4-bit opcode to the decode/control stage. It resolves jump/beq/bne redirects using control outputs from the current decode cycle and honours decode stalls.

## Interface
- RESET_PC, 16'h0000, word address fetched first after reset
- NOP_INSTR, 16'h0000, value driven on instr when instr_valid=0
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_addr  out  16  instruction memory word address (combinational from state)
- imem_rdata  in  16  memory data; valid one cycle after imem_addr
- stall  in  1  decode cannot accept; hold current instruction
- jump, beq, bne  in  1 each  control-unit outputs for the instruction on instr this cycle
- alu_zero  in  1  zero flag for the beq/bne compare of this instruction
- instr  out  16  instruction in decode
- opcode  out  4  instr[15:12], to control unit
- pc  out  16  address of instr
- pc_plus1  out  16  pc + 1 (mod 2^16)
- instr_valid  out  1  instr/pc are a real instruction
- redirect  out  1  taken jump/branch this cycle

## Operation
- State: fetch_pc F (16b), decode pc register D (16b), valid_d (1b).
- Outputs: instr = valid_d ? imem_rdata : NOP_INSTR; opcode = instr[15:12]; pc = D; pc_plus1 = D+1; instr_valid = valid_d.
- imem_addr = (stall & valid_d) ? D : F.
- Taken: redirect = valid_d & ~stall & (jump | (beq & alu_zero) | (bne & ~alu_zero)).
- Target: jump -> {pc_plus1[15:12], instr[11:0]}; branch -> pc_plus1 + sign_extend(instr[5:0]). Jump has priority if jump and beq/bne both asserted. Arithmetic 16-bit, wraps mod 2^16.
- Next state, priority order:
  - rst: F<=RESET_PC, D<=RESET_PC, valid_d<=0.
  - stall & valid_d: hold F, D, valid_d (re-fetch of D keeps imem_rdata stable).
  - redirect: F<=target, valid_d<=0 (wrong-path fetch at F squashed), D don't-care.
  - otherwise: D<=F, F<=F+1, valid_d<=1.
- stall while valid_d=0 is ignored (bubble advances).
- jump/beq/bne/alu_zero ignored when valid_d=0 or stall=1.

## Timing
- Reset values: instr_valid=0, instr=NOP_INSTR, opcode=NOP_INSTR[15:12], pc=RESET_PC, pc_plus1=RESET_PC+1, redirect=0, imem_addr=RESET_PC.
- First cycle after rst deasserts: imem_addr=RESET_PC. Next cycle: instr_valid=1, pc=RESET_PC, instr=mem[RESET_PC].
- Steady state: one instruction per cycle, fetch-to-decode latency 1 cycle.
- Taken redirect in cycle n: cycle n+1 instr_valid=0, imem_addr=target; cycle n+2 instr_valid=1, pc=target. Penalty: exactly 1 bubble.
- Not-taken branch: no bubble.
- Stall: instr/pc/opcode unchanged for every stalled cycle and the cycle after release; next instruction appears the cycle after that (sequential F resumes, no loss, no duplicate).
- rst asserted mid-stall or on a redirect cycle: reset wins; behaviour identical to power-on reset.
- F at 16'hFFFF increments to 16'h0000.

## Test plan
- Reset: hold rst 2 cycles, release, mem[i]=16'h1000+i -> instr_valid 0 then 1; pc sequence 0,1,2,3 with instr 16'h1000..16'h1003, opcode 4'h1.
- Stall: assert stall 3 cycles while pc=2 -> pc=2, instr=16'h1002 held 3 cycles; then pc=3,4 with no skip or repeat.
- beq: at pc=4, instr[5:0]=6'h3E (-2), beq=1, alu_zero=1 -> redirect=1, one bubble, next valid pc=3; same with alu_zero=0 -> no bubble, next pc=5.
- jump: at pc=16'h1005, instr[11:0]=12'h0A0, jump=1, beq=1, alu_zero=0 -> one bubble, next pc=16'h10A0 (jump priority).
- Wrap: RESET_PC=16'hFFFE -> pc sequence FFFE, FFFF, 0000; bne at pc=16'hFFFF, offset +1, alu_zero=0 -> target 16'h0001.
- Reset mid-operation: rst asserted during stall and during redirect cycle -> next cycle instr_valid=0, imem_addr=RESET_PC, then normal restart from RESET_PC.
